// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared constants for the pipeline hazard unit: forwarding one-hot bit order,
// scoreboard tag field layout and the hazard priority mode encoding.
package pipeline_hazard_unit_pkg;

  // Forwarding select bit positions, youngest producer at the top.
  localparam int FWD_NUM   = 5;
  localparam int FWD_X_ALU = 4;
  localparam int FWD_M_ALU = 3;
  localparam int FWD_M_MEM = 2;
  localparam int FWD_W_ALU = 1;
  localparam int FWD_W_MEM = 0;

  // Tag layout: {dst, mem, load, v}, dst occupies the top RA_W bits.
  localparam int TAG_V       = 0;
  localparam int TAG_LOAD    = 1;
  localparam int TAG_MEM     = 2;
  localparam int TAG_DST_LSB = 3;

  function automatic int tag_width(input int ra_w);
    return ra_w + 3;
  endfunction

  typedef enum logic [1:0] {
    HZ_NORMAL    = 2'd0,
    HZ_LU_STALL  = 2'd1,
    HZ_FLUSH     = 2'd2,
    HZ_MEM_STALL = 2'd3
  } hazard_mode_e;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// Pipeline-side view of the hazard unit: R-stage decode info in, stage control out.
// HAZARD_PERF_CNT_EN adds the three stall/flush performance counters.
interface pipeline_hazard_unit_if #(
  parameter int RA_W  = 3,
  parameter int FWD_W = 5
);
  logic            r_valid;
  logic            r_sa_valid;
  logic [RA_W-1:0] r_sa;
  logic            r_sb_valid;
  logic [RA_W-1:0] r_sb;
  logic            r_dst_valid;
  logic [RA_W-1:0] r_dst;
  logic            r_is_load;
  logic            r_is_mem;
  logic            mem_ready;
  logic            flush;
  logic            en_f;
  logic            en_r;
  logic            en_x;
  logic            en_m;
  logic            en_w;
  logic            bubble_x;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]     stall_lu_cnt;
  logic [31:0]     stall_mem_cnt;
  logic [31:0]     flush_cnt;
`endif

  modport master (
    output r_valid, r_sa_valid, r_sa, r_sb_valid, r_sb,
           r_dst_valid, r_dst, r_is_load, r_is_mem, mem_ready, flush,
`ifdef HAZARD_PERF_CNT_EN
    input  stall_lu_cnt, stall_mem_cnt, flush_cnt,
`endif
    input  en_f, en_r, en_x, en_m, en_w, bubble_x, fwd_a, fwd_b
  );

  modport slave (
    input  r_valid, r_sa_valid, r_sa, r_sb_valid, r_sb,
           r_dst_valid, r_dst, r_is_load, r_is_mem, mem_ready, flush,
`ifdef HAZARD_PERF_CNT_EN
    output stall_lu_cnt, stall_mem_cnt, flush_cnt,
`endif
    output en_f, en_r, en_x, en_m, en_w, bubble_x, fwd_a, fwd_b
  );

endinterface

// File: rtl/pipeline_hazard_unit_fwd_sel.sv
// Per-operand forwarding select: compares one source register against the
// X/M/W scoreboard tags and returns a one-hot select, youngest match winning.
module hazard_fwd_sel
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int RA_W  = 3,
  parameter int FWD_W = 5,
  parameter int TAG_W = RA_W + 3
) (
  input  logic             src_valid,
  input  logic [RA_W-1:0]  src,
  input  logic [TAG_W-1:0] x_tag,
  input  logic [TAG_W-1:0] m_tag,
  input  logic [TAG_W-1:0] w_tag,
  output logic [FWD_W-1:0] sel
);

  logic             x_hit_s;
  logic             m_hit_s;
  logic             w_hit_s;
  logic [FWD_W-1:0] sel_s;

  // A load in X has no result yet, so it can never be an X_ALU source.
  assign x_hit_s = x_tag[TAG_V] & ~x_tag[TAG_LOAD] & (x_tag[TAG_DST_LSB +: RA_W] == src);
  assign m_hit_s = m_tag[TAG_V] & (m_tag[TAG_DST_LSB +: RA_W] == src);
  assign w_hit_s = w_tag[TAG_V] & (w_tag[TAG_DST_LSB +: RA_W] == src);

  // Priority select from youngest (X) to oldest (W).
  always_comb begin
    sel_s = '0;
    if (!src_valid) begin
      sel_s = '0;
    end else if (x_hit_s) begin
      sel_s[FWD_X_ALU] = 1'b1;
    end else if (m_hit_s) begin
      if (m_tag[TAG_LOAD]) begin
        sel_s[FWD_M_MEM] = 1'b1;
      end else begin
        sel_s[FWD_M_ALU] = 1'b1;
      end
    end else if (w_hit_s) begin
      if (w_tag[TAG_LOAD]) begin
        sel_s[FWD_W_MEM] = 1'b1;
      end else begin
        sel_s[FWD_W_ALU] = 1'b1;
      end
    end else begin
      sel_s = '0;
    end
  end

  assign sel = sel_s;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for the F/R/X/M/W pipeline: X/M/W tag
// scoreboard, stage enables, X bubbles and operand forwarding selects.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int RA_W  = 3,
  parameter int FWD_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_unit_if.slave  hif
);

  localparam int TAG_W = tag_width(RA_W);

  if (FWD_W != FWD_NUM) begin : g_bad_fwd_w
    $error("pipeline_hazard_unit: FWD_W must be 5");
  end

  logic [TAG_W-1:0] x_tag_r, m_tag_r, w_tag_r;
  logic [TAG_W-1:0] x_tag_s, m_tag_s, w_tag_s;
  logic [TAG_W-1:0] r_tag_s;
  logic             pend_flush_r, pend_flush_s;
  logic             mem_stall_s, lu_stall_s, flush_eff_s;
  logic             sa_hit_x_s, sb_hit_x_s;
  hazard_mode_e     mode_s;
  logic             en_f_s, en_r_s, en_x_s, en_m_s, en_w_s, bubble_x_s;

  assign r_tag_s = {hif.r_dst, hif.r_is_mem, hif.r_is_load, hif.r_valid & hif.r_dst_valid};

  assign sa_hit_x_s  = hif.r_sa_valid & (hif.r_sa == x_tag_r[TAG_DST_LSB +: RA_W]);
  assign sb_hit_x_s  = hif.r_sb_valid & (hif.r_sb == x_tag_r[TAG_DST_LSB +: RA_W]);
  assign mem_stall_s = m_tag_r[TAG_V] & m_tag_r[TAG_MEM] & ~hif.mem_ready;
  assign lu_stall_s  = x_tag_r[TAG_V] & x_tag_r[TAG_LOAD] & hif.r_valid & (sa_hit_x_s | sb_hit_x_s);
  assign flush_eff_s = hif.flush | pend_flush_r;

  // Resolve which hazard condition governs this cycle.
  always_comb begin
    mode_s = HZ_NORMAL;
    if (mem_stall_s) begin
      mode_s = HZ_MEM_STALL;
    end else if (flush_eff_s) begin
      mode_s = HZ_FLUSH;
    end else if (lu_stall_s) begin
      mode_s = HZ_LU_STALL;
    end else begin
      mode_s = HZ_NORMAL;
    end
  end

  // Stage enables, bubble and next scoreboard contents for the chosen mode.
  always_comb begin
    en_f_s       = 1'b1;
    en_r_s       = 1'b1;
    en_x_s       = 1'b1;
    en_m_s       = 1'b1;
    en_w_s       = 1'b1;
    bubble_x_s   = ~hif.r_valid;
    x_tag_s      = r_tag_s;
    m_tag_s      = x_tag_r;
    w_tag_s      = m_tag_r;
    pend_flush_s = pend_flush_r;
    case (mode_s)
      HZ_MEM_STALL: begin
        // Everything up to M freezes; W drains and receives a bubble.
        en_f_s     = 1'b0;
        en_r_s     = 1'b0;
        en_x_s     = 1'b0;
        en_m_s     = 1'b0;
        bubble_x_s = 1'b0;
        x_tag_s    = x_tag_r;
        m_tag_s    = m_tag_r;
        w_tag_s    = m_tag_r;
        w_tag_s[TAG_V] = 1'b0;
        if (hif.flush) begin
          pend_flush_s = 1'b1;
        end else begin
          pend_flush_s = pend_flush_r;
        end
      end
      HZ_FLUSH: begin
        bubble_x_s     = 1'b1;
        x_tag_s        = r_tag_s;
        x_tag_s[TAG_V] = 1'b0;
        pend_flush_s   = 1'b0;
      end
      HZ_LU_STALL: begin
        en_f_s         = 1'b0;
        en_r_s         = 1'b0;
        bubble_x_s     = 1'b1;
        x_tag_s        = r_tag_s;
        x_tag_s[TAG_V] = 1'b0;
      end
      HZ_NORMAL: begin
        bubble_x_s = ~hif.r_valid;
        x_tag_s    = r_tag_s;
      end
      default: begin
        x_tag_s = '0;
        m_tag_s = '0;
        w_tag_s = '0;
      end
    endcase
  end

  // Scoreboard and pending-flush registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_tag_r      <= '0;
      m_tag_r      <= '0;
      w_tag_r      <= '0;
      pend_flush_r <= 1'b0;
    end else begin
      x_tag_r      <= x_tag_s;
      m_tag_r      <= m_tag_s;
      w_tag_r      <= w_tag_s;
      pend_flush_r <= pend_flush_s;
    end
  end

  assign hif.en_f     = en_f_s;
  assign hif.en_r     = en_r_s;
  assign hif.en_x     = en_x_s;
  assign hif.en_m     = en_m_s;
  assign hif.en_w     = en_w_s;
  assign hif.bubble_x = bubble_x_s;

  hazard_fwd_sel #(.RA_W(RA_W), .FWD_W(FWD_W), .TAG_W(TAG_W)) u_fwd_a (
    .src_valid (hif.r_sa_valid),
    .src       (hif.r_sa),
    .x_tag     (x_tag_r),
    .m_tag     (m_tag_r),
    .w_tag     (w_tag_r),
    .sel       (hif.fwd_a)
  );

  hazard_fwd_sel #(.RA_W(RA_W), .FWD_W(FWD_W), .TAG_W(TAG_W)) u_fwd_b (
    .src_valid (hif.r_sb_valid),
    .src       (hif.r_sb),
    .x_tag     (x_tag_r),
    .m_tag     (m_tag_r),
    .w_tag     (w_tag_r),
    .sel       (hif.fwd_b)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_lu_cnt_r, stall_mem_cnt_r, flush_cnt_r;

  // Saturating counters of the hazard mode actually applied each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_lu_cnt_r  <= 32'd0;
      stall_mem_cnt_r <= 32'd0;
      flush_cnt_r     <= 32'd0;
    end else begin
      if ((mode_s == HZ_LU_STALL) && (stall_lu_cnt_r != 32'hFFFF_FFFF)) begin
        stall_lu_cnt_r <= stall_lu_cnt_r + 32'd1;
      end else begin
        stall_lu_cnt_r <= stall_lu_cnt_r;
      end
      if ((mode_s == HZ_MEM_STALL) && (stall_mem_cnt_r != 32'hFFFF_FFFF)) begin
        stall_mem_cnt_r <= stall_mem_cnt_r + 32'd1;
      end else begin
        stall_mem_cnt_r <= stall_mem_cnt_r;
      end
      if ((mode_s == HZ_FLUSH) && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hif.stall_lu_cnt  = stall_lu_cnt_r;
  assign hif.stall_mem_cnt = stall_mem_cnt_r;
  assign hif.flush_cnt     = flush_cnt_r;
`endif

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage F/R/X/M/W pipeline. It keeps a registered scoreboard of destination tags for the X, M and W stages. From that scoreboard it produces per-stage enables, X-stage bubble insertion, and youngest-wins forwarding selects for two source operands. Over the previous combinational controller it adds:
- memory-wait stalls (mem_ready handshake)
- branch flush, including a flush held pending across a memory stall
- configurable register count

Parameters:
- RA_W, 3: register address width; register file holds 2**RA_W entries.
- FWD_W, 5: forwarding select width; fixed one-hot order {X_ALU, M_ALU, M_MEM, W_ALU, W_MEM}. Must be 5; any other value is a parameter error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- r_valid  in  1  R stage holds a real instruction
- r_sa_valid  in  1  operand A is read from the register file
- r_sa  in  RA_W  operand A register
- r_sb_valid  in  1  operand B is read
- r_sb  in  RA_W  operand B register
- r_dst_valid  in  1  R instruction writes a register
- r_dst  in  RA_W  destination register (decoder resolves SP/POP targets)
- r_is_load  in  1  result comes from memory (LD/POP)
- r_is_mem  in  1  instruction accesses memory in M
- mem_ready  in  1  M-stage memory access completes this cycle
- flush  in  1  branch taken, resolved in X; kill F and R
- en_f, en_r, en_x, en_m, en_w  out  1 each  stage register enables
- bubble_x  out  1  load NOP into X instead of R
- fwd_a  out  FWD_W  one-hot forward select for operand A; 0 means use the register file
- fwd_b  out  FWD_W  one-hot forward select for operand B; 0 means use the register file

Behaviour:
- Scoreboard: tags X, M and W. Each tag is {v, dst, load, mem}, all registered. Reset clears every v and the pending-flush flag.
- Combinational conditions:
  - mem_stall = M.v & M.mem & ~mem_ready
  - lu_stall = X.v & X.load & r_valid & ((r_sa_valid & r_sa==X.dst) | (r_sb_valid & r_sb==X.dst))
  - flush_eff = flush | pend_flush
- Priority (highest first): rst > mem_stall > flush_eff > lu_stall > normal.
- mem_stall:
  - en_f = en_r = en_x = en_m = 0; en_w = 1.
  - Next W.v = 0 (bubble into W); X and M tags hold.
  - If flush is asserted, set pend_flush.
- flush_eff, no mem_stall:
  - All enables 1; bubble_x = 1; next X.v = 0.
  - Clear pend_flush.
  - F is refetched by the PC logic outside this block.
- lu_stall only:
  - en_f = en_r = 0; en_x = en_m = en_w = 1; bubble_x = 1.
  - Next X.v = 0. Stall lasts exactly 1 cycle; the load then sits in M and is forwarded via M_MEM.
- Normal:
  - All enables 1; bubble_x = ~r_valid.
  - Next X = {r_valid & r_dst_valid, r_dst, r_is_load, r_is_mem}.
  - M <= X; W <= M.
- Forwarding, evaluated per operand with youngest match winning:
  - Operand valid and equals X.dst with X.v & ~X.load: X_ALU.
  - Else equals M.dst with M.v: M_MEM if M.load, otherwise M_ALU.
  - Else equals W.dst with W.v: W_MEM if W.load, otherwise W_ALU.
  - Else 0.
  - An invalid operand always yields 0.
  - At most one bit is set.
- Outputs are combinational from registered tags and current inputs. Latency from a R-stage input to its tag appearing in X is 1 cycle.
- rst asserted mid-stall: the next cycle behaves as empty pipeline; pend_flush is cleared.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds three output ports:
  - stall_lu_cnt (32 bit): increments each lu_stall cycle that is not masked by a higher-priority condition.
  - stall_mem_cnt (32 bit): increments each mem_stall cycle.
  - flush_cnt (32 bit): increments each cycle flush_eff is applied.
- All three are cleared by rst and saturate at all-ones.
- When not defined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - fwd index constants FWD_X_ALU=4, FWD_M_ALU=3, FWD_M_MEM=2, FWD_W_ALU=1, FWD_W_MEM=0
  - tag field layout
- One sub-module: hazard_fwd_sel. It is purely combinational, takes one operand plus the three tags and returns the one-hot select. It is instantiated twice (A, B).

Test Plan:
- ADD r1 then ADD uses r1 as src A: cycle 2 gives fwd_a=5'b10000, all enables 1, no bubble.
- LD r2 then SUB reads r2 as src B: 1 cycle with en_f=en_r=0 and bubble_x=1; next cycle fwd_b=5'b00100.
- r3 written by instructions in X (ALU) and M (ALU), R reads r3: fwd_a=5'b10000, youngest wins.
- LD in M with mem_ready held low 3 cycles: en_f..en_m=0 and en_w=1 for 3 cycles, W.v=0; the tag advances when mem_ready=1.
- flush pulsed during mem_stall: no effect while stalled; on the first ready cycle bubble_x=1 and the flush counter increments by 1 (HAZARD_PERF_CNT_EN).
- rst asserted during lu_stall: next cycle all enables 1, fwd_a=fwd_b=0, bubble_x follows r_valid.
